// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
//   ADDR_W        - PC / instruction-memory address width
//   MEM_DEPTH     - number of valid instruction words
//   fetch_state_t - fetch sequencer states
//   next_pc_sel_t - next-PC source select
package cpu_pkg;

  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_JMP  = 2'd2,
    SEL_BR   = 2'd3
  } next_pc_sel_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Optional feature macro: FETCH_BOUNDS_EN (adds MEM_DEPTH and out_of_range).
// Ports:
//   pc           - current PC
//   sel          - next-PC source (hold / increment / jump / branch)
//   jmp_target   - absolute jump destination
//   br_offset    - signed branch offset, relative to pc+1
//   next_pc      - selected next PC, modulo 2^ADDR_W
//   out_of_range - next_pc >= MEM_DEPTH (FETCH_BOUNDS_EN only)
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int OFF_W  = 8
`ifdef FETCH_BOUNDS_EN
  ,
  parameter int MEM_DEPTH = cpu_pkg::MEM_DEPTH
`endif
) (
  input  logic [ADDR_W-1:0] pc,
  input  next_pc_sel_t      sel,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [OFF_W-1:0]  br_offset,
  output logic [ADDR_W-1:0] next_pc
`ifdef FETCH_BOUNDS_EN
  ,
  output logic              out_of_range
`endif
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;

  assign pc_inc  = pc + ADDR_W'(1);
  // Size cast of a signed operand sign-extends the offset to ADDR_W.
  assign off_ext = ADDR_W'($signed(br_offset));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    next_pc = pc;
    unique case (sel)
      SEL_INC: next_pc = pc_inc;
      SEL_JMP: next_pc = jmp_target;
      SEL_BR:  next_pc = pc_inc + off_ext;
      default: next_pc = pc;
    endcase
  end

`ifdef FETCH_BOUNDS_EN
  assign out_of_range = (32'(next_pc) >= 32'(MEM_DEPTH));
`endif

endmodule

// File: rtl/fetch_unit.sv
// Program-counter and fetch sequencer feeding the instruction memory.
// Optional feature macro: FETCH_BOUNDS_EN (out-of-range PC moves to a sticky
// FAULT state instead of wrapping).
// Ports:
//   clk, rst_n   - clock (rising edge), async active-low reset
//   stall        - hold PC this cycle; redirects that cycle are dropped
//   halt_req     - current instruction is a halt
//   resume       - leave HALT
//   jmp          - absolute jump to jmp_target
//   br_taken     - branch to pc + 1 + sext(br_offset)
//   pc           - current PC (instruction-memory address)
//   pc_plus1     - pc + 1 modulo 2^ADDR_W (link value)
//   fetch_valid  - instruction at pc is to be executed
//   halted       - sequencer is in HALT
//   fault        - sequencer is in FAULT
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = cpu_pkg::ADDR_W,
  parameter int          MEM_DEPTH = cpu_pkg::MEM_DEPTH,
  parameter int unsigned RESET_PC  = 0,
  parameter int          OFF_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              br_taken,
  input  logic [OFF_W-1:0]  br_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fetch_valid,
  output logic              halted,
  output logic              fault
);

  fetch_state_t      state, state_next;
  next_pc_sel_t      sel;
  logic [ADDR_W-1:0] next_pc;
  logic              pc_load;

`ifdef FETCH_BOUNDS_EN
  logic out_of_range;

  next_pc_calc #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_next_pc_calc (
    .pc           (pc),
    .sel          (sel),
    .jmp_target   (jmp_target),
    .br_offset    (br_offset),
    .next_pc      (next_pc),
    .out_of_range (out_of_range)
  );
`else
  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_next_pc_calc (
    .pc         (pc),
    .sel        (sel),
    .jmp_target (jmp_target),
    .br_offset  (br_offset),
    .next_pc    (next_pc)
  );
`endif

  // Sequencing: halt_req > stall > jmp > br_taken > increment while running.
  always_comb begin
    sel        = SEL_HOLD;
    state_next = state;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (halt_req) begin
          sel        = SEL_INC;
          state_next = HALT;
        end else if (stall) begin
          sel = SEL_HOLD;
        end else if (jmp) begin
          sel = SEL_JMP;
        end else if (br_taken) begin
          sel = SEL_BR;
        end else begin
          sel = SEL_INC;
        end
      end
      HALT: begin
        if (resume) state_next = RUN;
      end
      default: state_next = state;
    endcase

    pc_load = (sel != SEL_HOLD);
`ifdef FETCH_BOUNDS_EN
    // An out-of-range target freezes the PC and parks the sequencer in FAULT.
    if (pc_load && out_of_range) begin
      pc_load    = 1'b0;
      state_next = FAULT;
    end
`endif
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its peers, matching the hardware it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= ADDR_W'(RESET_PC);
    end else begin
      state <= state_next;
      if (pc_load) pc <= next_pc;
    end
  end

  assign pc_plus1    = pc + ADDR_W'(1);
  assign fetch_valid = (state == RUN) && !stall;
  assign halted      = (state == HALT);
`ifdef FETCH_BOUNDS_EN
  assign fault       = (state == FAULT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle CPU. It sits directly upstream of the instruction memory and drives its 10-bit address input. It selects the next PC from sequential increment, PC-relative branch or absolute jump, and supports stall, halt/resume and an optional out-of-range fault. Each cycle's PC is registered, so the combinational instruction memory returns the addressed instruction in the same cycle.

## Interface
- ADDR_W, 10, PC / instruction-memory address width
- MEM_DEPTH, 1000, number of valid instruction words (addresses 0..MEM_DEPTH-1)
- RESET_PC, 0, PC value loaded at reset
- OFF_W, 8, signed branch offset width
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- stall  input  1  hold PC this cycle
- halt_req  input  1  current instruction is a halt
- resume  input  1  leave HALT
- jmp  input  1  absolute jump request
- jmp_target  input  ADDR_W  jump destination
- br_taken  input  1  taken branch request
- br_offset  input  OFF_W  signed offset, relative to PC+1
- pc  output  ADDR_W  current PC, to instruction memory address
- pc_plus1  output  ADDR_W  PC+1 modulo 2^ADDR_W (link value)
- fetch_valid  output  1  instruction at pc is to be executed
- halted  output  1  state is HALT
- fault  output  1  state is FAULT

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset (async): state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0, fault=0; pc_plus1=RESET_PC+1.
- BOOT: one cycle, pc held, then RUN unconditionally.
- RUN, priority per cycle: halt_req > stall > jmp > br_taken > increment.
  - halt_req: pc <= pc+1, go to HALT.
  - stall: pc held; any jmp/br_taken that cycle is dropped. Decode re-presents it.
  - jmp: pc <= jmp_target.
  - br_taken: pc <= pc + 1 + sext(br_offset).
  - otherwise: pc <= pc+1.
- All PC arithmetic is modulo 2^ADDR_W; br_offset is sign-extended to ADDR_W before the add.
- resume is ignored outside HALT. halt_req together with resume in RUN: halt wins.
- HALT: pc held; resume -> RUN next cycle with pc unchanged. Other requests are ignored.
- FAULT: only exists with FETCH_BOUNDS_EN. It is sticky until reset; pc held.
- fetch_valid=1 only in RUN and not stall. halted=1 only in HALT. fault=1 only in FAULT.

## Timing
- pc, state and flags are registered and update on the rising clk edge. pc_plus1 is combinational from pc.
- Redirect latency: a jmp/br_taken sampled at edge N appears on pc after edge N. There are no delay slots.
- Halt: halt_req at edge N gives halted=1 and fetch_valid=0 from edge N.
- Resume: resume at edge M gives RUN and fetch_valid=1 from edge M.
- First fetch_valid=1 occurs in the second cycle after rst_n deasserts.
- rst_n asserted mid-operation forces reset values immediately, regardless of clk.

## Configuration
- FETCH_BOUNDS_EN defined:
  - If the selected next PC is >= MEM_DEPTH (after modulo wrap), the PC does not update.
  - State moves to FAULT and fault=1.
  - Applies to increment, branch and jump alike. halt_req's pc+1 is checked the same way.
- FETCH_BOUNDS_EN undefined:
  - No FAULT state; fault is tied to 0.
  - Out-of-range PCs are issued unchanged and wrap at 2^ADDR_W.

## Structure
- cpu_pkg holds:
  - ADDR_W and MEM_DEPTH constants
  - fetch_state_t enum {BOOT, RUN, HALT, FAULT}
  - next_pc_sel_t enum {SEL_HOLD, SEL_INC, SEL_JMP, SEL_BR}
- One sub-module, next_pc_calc, is natural here. It is combinational and takes pc, sel, jmp_target and br_offset. It outputs next_pc and, under FETCH_BOUNDS_EN, out_of_range.
- The state register and PC register stay in fetch_unit.

## Test plan
- Reset then idle: rst_n low -> pc=0, fetch_valid=0. Release -> BOOT one cycle, then pc steps 0,1,2,3 with fetch_valid=1.
- Branch/jump: at pc=5, br_taken with br_offset=-3 -> pc=3. At pc=3, jmp with jmp_target=500 -> pc=500. At pc=0, br_offset=-2 -> pc=1023 (FETCH_BOUNDS_EN undefined).
- Stall priority: at pc=7, stall+jmp to 100 for 2 cycles -> pc stays 7, fetch_valid=0. Then jmp alone -> pc=100.
- Halt/resume: at pc=22, halt_req -> pc=23, halted=1, fetch_valid=0. br_taken while halted is ignored. resume -> RUN, pc=23, then 24.
- Bounds (FETCH_BOUNDS_EN): at pc=999, increment -> pc stays 999, fault=1 and remains 1. Asserting rst_n low -> pc=0, fault=0.
- Async reset mid-run: drop rst_n between edges at pc=12 -> pc=0 and fetch_valid=0 before the next edge.
